// File: rtl/time_count.sv
// time_count: 24-hour time-of-day counter with prescaler, delayed load from the set bus,
// registered BCD digits and second/day strobes.
module time_count #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int CNT_W    = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_req,
   input  logic       run,
   input  logic [7:0] hour_set,
   input  logic [7:0] min_set,
   input  logic [7:0] sec_set,
   output logic [7:0] hour,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       sec_tick,
   output logic       day_wrap
);
   logic             load_q, load_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
   logic [7:0]       hour_bcd_q, hour_bcd_d, min_bcd_q, min_bcd_d, sec_bcd_q, sec_bcd_d;
   logic             sec_tick_q, sec_tick_d, day_wrap_q, day_wrap_d;
   logic             tick, sec_end, min_end, hour_end;

   function automatic logic [7:0] to_bcd(input logic [7:0] v);
      return {4'(v / 8'd10), 4'(v % 8'd10)};
   endfunction

   // load_req is delayed one cycle so the set bus has settled when it is captured
   always_comb begin
      load_d     = load_req;
      tick       = run && !load_q && (cnt_q == CNT_W'(CLK_FREQ - 1));
      sec_end    = sec_q == 8'd59;
      min_end    = min_q == 8'd59;
      hour_end   = hour_q == 8'd23;
      cnt_d      = (load_q || tick) ? '0 : run ? cnt_q + 1'b1 : cnt_q;
      sec_d      = load_q ? (sec_set > 8'd59 ? 8'd0 : sec_set)
                 : tick ? (sec_end ? 8'd0 : sec_q + 8'd1) : sec_q;
      min_d      = load_q ? (min_set > 8'd59 ? 8'd0 : min_set)
                 : (tick && sec_end) ? (min_end ? 8'd0 : min_q + 8'd1) : min_q;
      hour_d     = load_q ? (hour_set > 8'd23 ? 8'd0 : hour_set)
                 : (tick && sec_end && min_end) ? (hour_end ? 8'd0 : hour_q + 8'd1) : hour_q;
      sec_tick_d = tick;
      day_wrap_d = tick && sec_end && min_end && hour_end;
      hour_bcd_d = to_bcd(hour_d);
      min_bcd_d  = to_bcd(min_d);
      sec_bcd_d  = to_bcd(sec_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_q     <= 1'b0;
         cnt_q      <= '0;
         hour_q     <= 8'd0;
         min_q      <= 8'd0;
         sec_q      <= 8'd0;
         hour_bcd_q <= 8'd0;
         min_bcd_q  <= 8'd0;
         sec_bcd_q  <= 8'd0;
         sec_tick_q <= 1'b0;
         day_wrap_q <= 1'b0;
      end else begin
         load_q     <= load_d;
         cnt_q      <= cnt_d;
         hour_q     <= hour_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         hour_bcd_q <= hour_bcd_d;
         min_bcd_q  <= min_bcd_d;
         sec_bcd_q  <= sec_bcd_d;
         sec_tick_q <= sec_tick_d;
         day_wrap_q <= day_wrap_d;
      end
   end

   assign hour     = hour_q;
   assign min      = min_q;
   assign sec      = sec_q;
   assign hour_bcd = hour_bcd_q;
   assign min_bcd  = min_bcd_q;
   assign sec_bcd  = sec_bcd_q;
   assign sec_tick = sec_tick_q;
   assign day_wrap = day_wrap_q;
endmodule

// File: tb/tb_time_count.sv
// tb_time_count: scoreboard bench for time_count; reference model keeps time as
// seconds-of-day and a cycle count within the current second.
module tb_time_count;
   localparam int F = 4;
   localparam int DAY = 86400;

   logic       clk = 1'b0, rst = 1'b0, load_req = 1'b0, run = 1'b0;
   logic [7:0] hour_set = 8'd0, min_set = 8'd0, sec_set = 8'd0;
   logic [7:0] hour, min, sec, hour_bcd, min_bcd, sec_bcd;
   logic       sec_tick, day_wrap;
   logic [49:0] act;

   typedef logic [49:0] exp_t;
   exp_t q[$];
   int   n_chk = 0, n_fail = 0;
   int   m_t = 0, m_cnt = 0;
   bit   m_ld = 1'b0;

   time_count #(.CLK_FREQ(F), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .load_req(load_req), .run(run),
      .hour_set(hour_set), .min_set(min_set), .sec_set(sec_set),
      .hour(hour), .min(min), .sec(sec),
      .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
      .sec_tick(sec_tick), .day_wrap(day_wrap)
   );

   always #5 clk = ~clk;
   assign act = {hour, min, sec, hour_bcd, min_bcd, sec_bcd, sec_tick, day_wrap};

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic exp_t expv(input int t, input bit tk, input bit wr);
      int h, mi, s;
      h  = t / 3600;
      mi = (t / 60) % 60;
      s  = t % 60;
      return {8'(h), 8'(mi), 8'(s), bcd(h), bcd(mi), bcd(s), tk, wr};
   endfunction

   // drive inputs for the coming edge and predict the state after it
   task automatic drive(input bit lr, input bit rn, input int h, input int mi, input int s);
      bit tk, wr;
      tk = 1'b0;
      wr = 1'b0;
      load_req = lr;
      run      = rn;
      hour_set = 8'(h);
      min_set  = 8'(mi);
      sec_set  = 8'(s);
      if (m_ld) begin
         m_t   = (h > 23 ? 0 : h) * 3600 + (mi > 59 ? 0 : mi) * 60 + (s > 59 ? 0 : s);
         m_cnt = 0;
      end else if (rn) begin
         if (m_cnt == F - 1) begin
            m_cnt = 0;
            tk    = 1'b1;
            wr    = (m_t == DAY - 1);
            m_t   = (m_t + 1) % DAY;
         end else m_cnt++;
      end
      m_ld = lr;
      q.push_back(expv(m_t, tk, wr));
   endtask

   task automatic cyc(input bit lr, input bit rn, input int h, input int mi, input int s);
      @(negedge clk);
      drive(lr, rn, h, mi, s);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_chk++;
      if (act !== '0) begin
         n_fail++;
         $display("FAIL reset_state actual=%h required=%h", act, 50'h0);
      end
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      m_t   = 0;
      m_cnt = 0;
      m_ld  = 1'b0;
      drive(1'b0, 1'b1, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, act, e);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin : stim
      do_reset();
      repeat (6) cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 12, 34, 56);
      repeat (6) cyc(0, 1, 12, 34, 56);
      cyc(1, 1, 23, 59, 59);
      repeat (6) cyc(0, 1, 23, 59, 59);
      cyc(1, 1, 9, 59, 59);
      repeat (6) cyc(0, 1, 9, 59, 59);
      cyc(1, 1, 30, 61, 75);
      repeat (3) cyc(0, 1, 30, 61, 75);
      cyc(1, 0, 1, 2, 3);
      cyc(0, 0, 1, 2, 3);
      repeat (2) cyc(0, 1, 1, 2, 3);
      repeat (10) cyc(0, 0, 1, 2, 3);
      repeat (3) cyc(0, 1, 1, 2, 3);
      repeat (6) cyc(1, 1, 5, 6, 7);
      repeat (6) cyc(0, 1, 5, 6, 7);
      cyc(1, 1, 0, 0, 10);
      cyc(0, 1, 0, 0, 10);
      repeat (2) cyc(0, 1, 0, 0, 10);
      cyc(1, 1, 1, 1, 1);
      repeat (6) cyc(0, 1, 1, 1, 1);
      do_reset();
      repeat (5) cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(2) == 0)
            cyc($urandom_range(9) == 0, $urandom_range(3) != 0, 23, 59, 59);
         else
            cyc($urandom_range(9) == 0, $urandom_range(3) != 0,
                int'($urandom_range(31)), int'($urandom_range(63)), int'($urandom_range(63)));
      end
      repeat (3) @(posedge clk);
      #2;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/time_count.md
# time_count

Running time-of-day counter that sits directly downstream of the time-setting stage. It keeps hours, minutes and seconds in 24-hour format, advances one second per `CLK_FREQ` clock cycles, and reloads from the `hour_set`/`min_set`/`sec_set` bus when the user confirms a new time. It drives the display stage with binary values, BCD digit pairs and second/day strobes.

## Interface
- `CLK_FREQ`, 50_000_000: clock cycles per second; legal range ≥2. The bench uses 4.
- `CNT_W`, 26: prescaler width; must satisfy 2^CNT_W ≥ CLK_FREQ.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high (one clock; reset asynchronous and active-high).
- `load_req`  in  1  pulse; driven by the same confirm strobe that makes the setting stage capture the set bus.
- `run`  in  1  1 = count, 0 = freeze time and prescaler.
- `hour_set`  in  8  binary 0..23 from the setting stage.
- `min_set`  in  8  binary 0..59.
- `sec_set`  in  8  binary 0..59.
- `hour`  out  8  current hour, binary.
- `min`  out  8  current minute, binary.
- `sec`  out  8  current second, binary.
- `hour_bcd`  out  8  {tens, units} BCD of `hour`.
- `min_bcd`  out  8  {tens, units} BCD of `min`.
- `sec_bcd`  out  8  {tens, units} BCD of `sec`.
- `sec_tick`  out  1  one-cycle pulse in the cycle after the seconds advance.
- `day_wrap`  out  1  one-cycle pulse in the cycle after 23:59:59 → 00:00:00.

## Operation
- Reset (async): all outputs 0, prescaler 0, internal `load_d` 0.
- The setting stage updates the set bus on the same edge that samples its confirm strobe. The block therefore registers `load_req` into `load_d` and loads on the next edge, when the bus is stable.
- Load (`load_d`=1):
  - `hour`/`min`/`sec` take the set bus.
  - Out-of-range values are clamped: hour >23 → 0; min or sec >59 → 0.
  - Prescaler clears to 0. `sec_tick` and `day_wrap` stay 0 that cycle.
  - Load takes effect whatever the value of `run`.
- Prescaler: counts 0..CLK_FREQ-1 while `run`=1 and no load. The tick condition is prescaler == CLK_FREQ-1; the prescaler then wraps to 0.
- On tick:
  - `sec` increments; 59 → 0 carries into `min`.
  - `min` 59 → 0 carries into `hour`.
  - `hour` 23 → 0 asserts `day_wrap`.
  - All digits update on the same edge.
- `run`=0: prescaler and time hold; no ticks.
- BCD outputs are registered and derived from the next-state binary value, so they change on the same edge as the binary outputs. Tens = value/10, units = value%10, each 4 bits.
- Priority: reset > load > tick > hold.

## Timing
- Load latency: `load_req` sampled at edge N; new time visible after edge N+1. The first tick after load occurs CLK_FREQ cycles after edge N+1.
- Second period: exactly CLK_FREQ cycles between consecutive `sec_tick` pulses while `run`=1.
- `sec_tick` and `day_wrap` are registered and high for exactly one cycle, coincident with the updated time.
- `load_req` held high for several cycles: the block reloads every cycle, the prescaler is held at 0, and no ticks occur.
- `run` deasserted mid-second: the prescaler keeps its count. On reassertion, counting resumes from that count, so the partial second is preserved.
- Reset mid-operation: outputs return to 0 immediately. After release, counting starts from 00:00:00 with the prescaler at 0.

## Test plan
- Reset with `run`=1, CLK_FREQ=4: outputs 00:00:00, BCD 0x00. First `sec_tick` 4 cycles after reset release; `sec`=1, `sec_bcd`=0x01.
- Set bus 12:34:56 with a one-cycle `load_req`: outputs 12:34:56 and BCD 0x12/0x34/0x56 one cycle after the sample edge. Next tick 4 cycles later gives 12:34:57.
- Load 23:59:59, run: the next tick gives 00:00:00. `day_wrap` and `sec_tick` are both high for one cycle.
- Load 09:59:59, tick: result 10:00:00 with `hour_bcd`=0x10.
- Load with bus 30:61:75: clamped to 00:00:00.
- `run` low for 10 cycles after 2 prescaler counts: no tick and time unchanged. After `run` rises, the tick arrives 2 cycles later. A load issued in the same cycle as a tick wins: loaded value shown and no `sec_tick`.
